// File: rtl/custom_io_pkg.sv
// ---------------------------------------------------------------------------
// custom_io_pkg
// Shared definitions for the custom_IO AXI4-Lite register block:
//   - byte offsets of the four registers (decoded on address bits [3:2])
//   - AXI response code used for every response
//   - write / read channel state enums
//   - helper that expands a 4-bit WSTRB into a 32-bit bit mask
// ---------------------------------------------------------------------------
package custom_io_pkg;

  localparam logic [3:0] ADDR_OUT      = 4'h0;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'h4;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'h8;
  localparam logic [3:0] ADDR_IN       = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Expand byte enables into a per-bit write mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/io_edge_sync.sv
// ---------------------------------------------------------------------------
// io_edge_sync
// Two-flop synchronizer for asynchronous inputs followed by a "previous"
// flop, giving a synchronized view and a one-cycle rising-edge pulse.
// Ports:
//   clk       in   clock
//   rst       in   synchronous, active-high reset (all flops to 0)
//   i_async   in   C_NUM_IO asynchronous inputs
//   o_sync    out  C_NUM_IO synchronized inputs
//   o_rise    out  C_NUM_IO rising-edge pulse (o_sync & ~previous)
// ---------------------------------------------------------------------------
module io_edge_sync #(
  parameter int C_NUM_IO = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_NUM_IO-1:0] i_async,
  output logic [C_NUM_IO-1:0] o_sync,
  output logic [C_NUM_IO-1:0] o_rise
);

  logic [C_NUM_IO-1:0] r_meta;
  logic [C_NUM_IO-1:0] r_sync;
  logic [C_NUM_IO-1:0] r_prev;

  // Synchronizer chain plus previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/custom_io_axil_regs.sv
// ---------------------------------------------------------------------------
// custom_io_axil_regs
// AXI4-Lite responder register file for the custom_IO peripheral.
//   0x0 OUT      RW byte-strobed, drives io_out
//   0x4 IRQ_EN   RW byte-strobed, masks irq
//   0x8 IRQ_STAT set by input rising edge, write-1-to-clear (set wins)
//   0xC IN       synchronized io_in, read-only
// Ports:
//   ACLK / ARESET          clock, synchronous active-high reset
//   S_AXI_AW* / W* / B*    write address, data, response channels
//   S_AXI_AR* / R*         read address and data channels
//   io_in                  asynchronous inputs
//   io_out                 OUT register
//   irq                    registered |(IRQ_STAT & IRQ_EN)
// ---------------------------------------------------------------------------
module custom_io_axil_regs
  import custom_io_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_IO           = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_NUM_IO-1:0]             io_in,
  output logic [C_NUM_IO-1:0]             io_out,
  output logic                            irq
);

  wr_state_t r_wstate, w_wstate_next;
  rd_state_t r_rstate, w_rstate_next;

  logic [C_NUM_IO-1:0] r_out;
  logic [C_NUM_IO-1:0] r_irq_en;
  logic [C_NUM_IO-1:0] r_irq_stat;
  logic                r_irq;
  logic [31:0]         r_rdata;

  logic                w_wr_fire;
  logic                w_rd_fire;
  logic [31:0]         w_mask32;
  logic [C_NUM_IO-1:0] w_mask;
  logic [C_NUM_IO-1:0] w_wbits;
  logic [C_NUM_IO-1:0] w_clr;
  logic [C_NUM_IO-1:0] w_sync;
  logic [C_NUM_IO-1:0] w_rise;
  logic [31:0]         w_rd_word;
  logic [3:0]          w_wsel;
  logic [3:0]          w_rsel;

  // Protection bits and sub-word address bits carry no meaning here.
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

  io_edge_sync #(.C_NUM_IO(C_NUM_IO)) u_sync (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_async (io_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  // Write channel next-state; AW and W are taken together in one cycle only.
  always_comb begin
    w_wstate_next = r_wstate;
    w_wr_fire     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          w_wr_fire     = 1'b1;
          w_wstate_next = W_RESP;
        end else begin
          w_wstate_next = W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_wstate_next = W_IDLE;
        end else begin
          w_wstate_next = W_RESP;
        end
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Read channel next-state.
  always_comb begin
    w_rstate_next = r_rstate;
    w_rd_fire     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          w_rd_fire     = 1'b1;
          w_rstate_next = R_DATA;
        end else begin
          w_rstate_next = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          w_rstate_next = R_IDLE;
        end else begin
          w_rstate_next = R_DATA;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  assign w_wsel   = {S_AXI_AWADDR[3:2], 2'b00};
  assign w_rsel   = {S_AXI_ARADDR[3:2], 2'b00};
  assign w_mask32 = strb_to_mask(S_AXI_WSTRB[3:0]);
  assign w_mask   = w_mask32[C_NUM_IO-1:0];
  assign w_wbits  = S_AXI_WDATA[C_NUM_IO-1:0] & w_mask;
  assign w_clr    = (w_wr_fire && (w_wsel == ADDR_IRQ_STAT)) ? w_wbits : '0;

  // Read mux; unused upper bits stay zero.
  always_comb begin
    w_rd_word = 32'h0000_0000;
    case (w_rsel)
      ADDR_OUT:      w_rd_word[C_NUM_IO-1:0] = r_out;
      ADDR_IRQ_EN:   w_rd_word[C_NUM_IO-1:0] = r_irq_en;
      ADDR_IRQ_STAT: w_rd_word[C_NUM_IO-1:0] = r_irq_stat;
      ADDR_IN:       w_rd_word[C_NUM_IO-1:0] = w_sync;
      default:       w_rd_word = 32'h0000_0000;
    endcase
  end

  // Register file, status set/clear, irq and read-data capture.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_out      <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
      r_rdata    <= 32'h0000_0000;
    end else begin
      if (w_wr_fire && (w_wsel == ADDR_OUT)) begin
        r_out <= (r_out & ~w_mask) | w_wbits;
      end
      if (w_wr_fire && (w_wsel == ADDR_IRQ_EN)) begin
        r_irq_en <= (r_irq_en & ~w_mask) | w_wbits;
      end
      // A new edge in the same cycle as a clear keeps the bit set.
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_rise;
      r_irq      <= |(r_irq_stat & r_irq_en);
      if (w_rd_fire) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign S_AXI_AWREADY = w_wr_fire;
  assign S_AXI_WREADY  = w_wr_fire;
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = w_rd_fire;
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = r_rdata;
  assign io_out        = r_out;
  assign irq           = r_irq;

endmodule

// File: tb/tb_custom_io_axil_regs.sv
module tb_custom_io_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  custom_io_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .C_NUM_IO(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .io_in(io_in), .io_out(io_out), .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Register contents as the programmer sees them, plus three samples of
  // io_in history (an input edge shows up in STAT on the third clock).
  logic [7:0]  m_out = 8'h00, m_en = 8'h00, m_stat = 8'h00;
  logic [7:0]  m_h1 = 8'h00, m_h2 = 8'h00, m_h3 = 8'h00;
  logic        m_irq = 1'b0, m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  wire       m_wacc = !m_bvalid && S_AXI_AWVALID && S_AXI_WVALID;
  wire       m_racc = !m_rvalid && S_AXI_ARVALID;
  wire [7:0] m_rise = m_h2 & ~m_h3;
  wire [7:0] m_clr  = (m_wacc && S_AXI_AWADDR[3:2] == 2'd2 && S_AXI_WSTRB[0]) ? S_AXI_WDATA[7:0] : 8'h00;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {24'h0, m_out};
      2'd1:    return {24'h0, m_en};
      2'd2:    return {24'h0, m_stat};
      default: return {24'h0, m_h2};
    endcase
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_out <= 8'h00; m_en <= 8'h00; m_stat <= 8'h00;
      m_h1 <= 8'h00; m_h2 <= 8'h00; m_h3 <= 8'h00;
      m_irq <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= 32'h0;
    end else begin
      m_h1 <= io_in; m_h2 <= m_h1; m_h3 <= m_h2;
      m_irq <= |(m_stat & m_en);
      m_stat <= (m_stat & ~m_clr) | m_rise;
      if (m_wacc && S_AXI_WSTRB[0] && S_AXI_AWADDR[3:2] == 2'd0) m_out <= S_AXI_WDATA[7:0];
      if (m_wacc && S_AXI_WSTRB[0] && S_AXI_AWADDR[3:2] == 2'd1) m_en  <= S_AXI_WDATA[7:0];
      if (m_wacc) m_bvalid <= 1'b1;
      else if (S_AXI_BREADY) m_bvalid <= 1'b0;
      if (m_racc) begin
        m_rvalid <= 1'b1;
        m_rdata  <= m_read(S_AXI_ARADDR);
      end else if (S_AXI_RREADY) m_rvalid <= 1'b0;
    end
  end

  // Per-cycle comparison of registered outputs against the model.
  always @(negedge ACLK) begin
    chk("io_out", {24'h0, io_out}, {24'h0, m_out});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    chk("bvalid", {31'h0, S_AXI_BVALID}, {31'h0, m_bvalid});
    chk("rvalid", {31'h0, S_AXI_RVALID}, {31'h0, m_rvalid});
    if (m_rvalid) begin
      chk("rdata", S_AXI_RDATA, m_rdata);
      chk("rresp", {30'h0, S_AXI_RRESP}, 32'h0);
    end
    if (m_bvalid) chk("bresp", {30'h0, S_AXI_BRESP}, 32'h0);
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    do begin
      @(posedge ACLK); #1; n++;
    end while (!S_AXI_BVALID && n < 20);
    chk("wr_bvalid_seen", {31'h0, S_AXI_BVALID}, 32'h1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin
      @(posedge ACLK); #1; n++;
    end while (!S_AXI_RVALID && n < 20);
    chk("rd_rvalid_seen", {31'h0, S_AXI_RVALID}, 32'h1);
    d = S_AXI_RDATA;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    ARESET = 1'b1; io_in = 8'h00;
    S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'h0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'h0;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_io_out", {24'h0, io_out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_bvalid", {31'h0, S_AXI_BVALID}, 32'h0);
    chk("rst_rvalid", {31'h0, S_AXI_RVALID}, 32'h0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
    ARESET = 1'b0;

    // Basic map: OUT/EN store, STAT W1C of clear bits, IN read-only.
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, rd); chk("map_out", rd, 32'h1);
    axi_read(4'h4, rd); chk("map_en", rd, 32'h2);
    axi_read(4'h8, rd); chk("map_stat", rd, 32'h0);
    axi_read(4'hC, rd); chk("map_in", rd, 32'h0);

    // AW three cycles ahead of W.
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h5A; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
    repeat (3) begin
      #1 chk("aw_only_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
      chk("aw_only_wready", {31'h0, S_AXI_WREADY}, 32'h0);
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b1;
    #1 chk("aw_w_awready", {31'h0, S_AXI_AWREADY}, 32'h1);
    chk("aw_w_wready", {31'h0, S_AXI_WREADY}, 32'h1);
    @(posedge ACLK); #1;
    chk("aw_w_bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
    chk("aw_w_io_out", {24'h0, io_out}, 32'h5A);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;

    // BREADY held low with a second write pending.
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1 chk("bp_first_ready", {31'h0, S_AXI_AWREADY}, 32'h1);
    @(negedge ACLK);
    S_AXI_WDATA = 32'h22;
    chk("bp_first_io_out", {24'h0, io_out}, 32'h11);
    repeat (10) begin
      #1 chk("bp_hold_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
      chk("bp_hold_bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1;
    #1 chk("bp_release_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
    @(negedge ACLK);
    #1 chk("bp_second_awready", {31'h0, S_AXI_AWREADY}, 32'h1);
    @(posedge ACLK); #1;
    chk("bp_second_io_out", {24'h0, io_out}, 32'h22);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);

    // Rising edge on io_in[0] with IRQ_EN[0] set, then W1C.
    axi_write(4'h4, 32'h01, 4'hF);
    @(negedge ACLK); io_in = 8'h01;
    repeat (3) @(negedge ACLK);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    @(negedge ACLK);
    chk("irq_set", {31'h0, irq}, 32'h1);
    io_in = 8'h00;
    axi_read(4'h8, rd); chk("stat_bit0", rd, 32'h01);
    axi_write(4'h8, 32'h01, 4'hF);
    repeat (2) @(negedge ACLK);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    axi_read(4'h8, rd); chk("stat_cleared", rd, 32'h0);

    // Set-wins on io_in[1], then strobe-gated W1C.
    @(negedge ACLK); io_in = 8'h02;
    repeat (4) @(negedge ACLK);
    io_in = 8'h00;
    repeat (4) @(negedge ACLK);
    axi_read(4'h8, rd); chk("stat_bit1", rd, 32'h02);
    @(negedge ACLK); io_in = 8'h02;
    @(negedge ACLK);
    axi_write(4'h8, 32'h02, 4'hF);
    axi_read(4'h8, rd); chk("stat_set_wins", rd, 32'h02);
    axi_write(4'h8, 32'h02, 4'h0);
    axi_read(4'h8, rd); chk("stat_strb0_keep", rd, 32'h02);
    axi_write(4'h8, 32'h02, 4'h1);
    axi_read(4'h8, rd); chk("stat_strb1_clear", rd, 32'h0);
    axi_read(4'hC, rd); chk("in_view", rd, 32'h02);
    io_in = 8'h00;

    // Reset in the middle of a read.
    axi_write(4'h0, 32'hA5, 4'hF);
    chk("pre_rst_io_out", {24'h0, io_out}, 32'hA5);
    @(negedge ACLK);
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(posedge ACLK); #1;
    chk("midrd_rvalid", {31'h0, S_AXI_RVALID}, 32'h1);
    chk("midrd_rdata", S_AXI_RDATA, 32'hA5);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0; ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("midrd_rst_rvalid", {31'h0, S_AXI_RVALID}, 32'h0);
    chk("midrd_rst_io_out", {24'h0, io_out}, 32'h0);
    @(negedge ACLK);
    ARESET = 1'b0; S_AXI_RREADY = 1'b1;
    axi_read(4'h0, rd); chk("post_rst_out", rd, 32'h0);

    repeat (3) @(negedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
